imm_operand_encoder: RTL

//  Inverse of the decode-stage immediate generator: packs a 32-bit immediate plus register/funct

---
 rtl/imm_operand_encoder_pkg.sv | 43 ++++
 rtl/imm_operand_encoder_if.sv | 33 +++
 rtl/imm_operand_encoder_range_check.sv | 24 ++
 rtl/imm_operand_encoder.sv | 110 +++++++++++
 4 files changed

// File: rtl/imm_operand_encoder_pkg.sv
// Shared definitions for the immediate operand encoder: instruction format
// codes, the canonical NOP word and the captured request record.
package imm_operand_encoder_pkg;

    typedef enum logic [2:0] {
        RTYPE = 3'd0,
        ITYPE = 3'd1,
        STYPE = 3'd2,
        BTYPE = 3'd3,
        UTYPE = 3'd4,
        JTYPE = 3'd5
    } imm_type_e;

    // addi x0, x0, 0 -- emitted for the two unused type codes
    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    typedef struct packed {
        logic [2:0]  itype;
        logic [31:0] imm;
        logic [6:0]  opcode;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
    } enc_req_t;

    // True when every bit of the field is identical (sign-extension check).
    function automatic logic sign_run_ok(input logic [20:0] bits, input int unsigned len);
        logic ones;
        logic zeros;
        ones  = 1'b1;
        zeros = 1'b1;
        for (int unsigned i = 0; i < 21; i++) begin
            if (i < len) begin
                ones  = ones & bits[i];
                zeros = zeros & ~bits[i];
            end
        end
        return ones | zeros;
    endfunction

endpackage

// File: rtl/imm_operand_encoder_if.sv
// Request/response bundle of the immediate operand encoder. The slave side
// is the encoder; the master side issues requests and consumes words.
interface imm_operand_encoder_if #(
    parameter int ERR_CNT_W = 8
);
    logic                 in_valid;
    logic                 in_ready;
    logic [2:0]           in_type;
    logic [31:0]          in_imm;
    logic [6:0]           in_opcode;
    logic [4:0]           in_rd;
    logic [4:0]           in_rs1;
    logic [4:0]           in_rs2;
    logic [2:0]           in_funct3;
    logic [6:0]           in_funct7;
    logic                 out_valid;
    logic                 out_ready;
    logic [31:0]          out_inst;
    logic                 out_err;
    logic [ERR_CNT_W-1:0] err_cnt;

    modport master (
        output in_valid, in_type, in_imm, in_opcode, in_rd, in_rs1, in_rs2,
               in_funct3, in_funct7, out_ready,
        input  in_ready, out_valid, out_inst, out_err, err_cnt
    );

    modport slave (
        input  in_valid, in_type, in_imm, in_opcode, in_rd, in_rs1, in_rs2,
               in_funct3, in_funct7, out_ready,
        output in_ready, out_valid, out_inst, out_err, err_cnt
    );
endinterface

// File: rtl/imm_operand_encoder_range_check.sv
// Combinational representability check: flags an immediate that does not
// fit the selected format, and flags the two unused type codes.
module imm_range_check
    import imm_operand_encoder_pkg::*;
(
    input  logic [2:0]  itype,
    input  logic [31:0] imm,
    output logic        err
);

    // Per-format sign-run and alignment checks
    always_comb begin
        err = 1'b1;
        case (itype)
            RTYPE:        err = 1'b0;
            ITYPE, STYPE: err = ~sign_run_ok(imm[31:11], 21);
            BTYPE:        err = ~(sign_run_ok({1'b0, imm[31:12]}, 20) & ~imm[0]);
            UTYPE:        err = |imm[11:0];
            JTYPE:        err = ~(sign_run_ok({9'd0, imm[31:20]}, 12) & ~imm[0]);
            default:      err = 1'b1;
        endcase
    end

endmodule

// File: rtl/imm_operand_encoder.sv
// Immediate operand encoder: packs an immediate plus register/funct fields
// into an RV32I instruction word. Stage 1 captures the request and checks
// the immediate; stage 2 holds the packed word until the consumer takes it.
module imm_operand_encoder
    import imm_operand_encoder_pkg::*;
#(
    parameter int ERR_CNT_W = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    imm_operand_encoder_if.slave  bus
);

    localparam logic [ERR_CNT_W-1:0] ERR_CNT_MAX = {ERR_CNT_W{1'b1}};

    enc_req_t             s1_q;
    logic                 s1_v;
    logic                 s1_err;
    logic                 in_err;
    logic                 s2_free;
    logic                 in_ready;
    logic                 s1_load;
    logic [31:0]          pack_inst;
    logic                 out_valid_q;
    logic                 out_err_q;
    logic [31:0]          out_inst_q;
    logic [ERR_CNT_W-1:0] err_cnt_q;

    assign s2_free  = ~out_valid_q | bus.out_ready;
    assign in_ready = ~s1_v | s2_free;
    assign s1_load  = bus.in_valid & in_ready;

    imm_range_check u_range_check (
        .itype (bus.in_type),
        .imm   (bus.in_imm),
        .err   (in_err)
    );

    // Stage 1: capture request and its range-check verdict
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_v   <= 1'b0;
            s1_err <= 1'b0;
            s1_q   <= '0;
        end else if (s1_load) begin
            s1_v          <= 1'b1;
            s1_err        <= in_err;
            s1_q.itype    <= bus.in_type;
            s1_q.imm      <= bus.in_imm;
            s1_q.opcode   <= bus.in_opcode;
            s1_q.rd       <= bus.in_rd;
            s1_q.rs1      <= bus.in_rs1;
            s1_q.rs2      <= bus.in_rs2;
            s1_q.funct3   <= bus.in_funct3;
            s1_q.funct7   <= bus.in_funct7;
        end else if (s2_free) begin
            s1_v <= 1'b0;
        end
    end

    // Field packing per format; low bits are packed even for a failing immediate
    always_comb begin
        pack_inst = NOP_INST;
        case (s1_q.itype)
            RTYPE: pack_inst = {s1_q.funct7, s1_q.rs2, s1_q.rs1, s1_q.funct3,
                                s1_q.rd, s1_q.opcode};
            ITYPE: pack_inst = {s1_q.imm[11:0], s1_q.rs1, s1_q.funct3,
                                s1_q.rd, s1_q.opcode};
            STYPE: pack_inst = {s1_q.imm[11:5], s1_q.rs2, s1_q.rs1, s1_q.funct3,
                                s1_q.imm[4:0], s1_q.opcode};
            BTYPE: pack_inst = {s1_q.imm[12], s1_q.imm[10:5], s1_q.rs2, s1_q.rs1,
                                s1_q.funct3, s1_q.imm[4:1], s1_q.imm[11], s1_q.opcode};
            UTYPE: pack_inst = {s1_q.imm[31:12], s1_q.rd, s1_q.opcode};
            JTYPE: pack_inst = {s1_q.imm[20], s1_q.imm[10:1], s1_q.imm[11],
                                s1_q.imm[19:12], s1_q.rd, s1_q.opcode};
            default: pack_inst = NOP_INST;
        endcase
    end

    // Stage 2: output register, frozen while the consumer stalls
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_err_q   <= 1'b0;
            out_inst_q  <= '0;
        end else if (s2_free) begin
            out_valid_q <= s1_v;
            if (s1_v) begin
                out_inst_q <= pack_inst;
                out_err_q  <= s1_err;
            end
        end
    end

    // Saturating count of erroneous words handed to the consumer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_cnt_q <= '0;
        end else if (out_valid_q && bus.out_ready && out_err_q && (err_cnt_q != ERR_CNT_MAX)) begin
            err_cnt_q <= err_cnt_q + 1'b1;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out_inst  = out_inst_q;
    assign bus.out_err   = out_err_q;
    assign bus.err_cnt   = err_cnt_q;

endmodule
